// File: rtl/rsa_modexp_engine.sv
// RSA modular exponentiation m = c^d mod n, left-to-right square-and-multiply with a bit-serial modmul.
// Define RSA_CONST_TIME_EN to run the multiply pass for every exponent bit (fixed latency).
//
// state  | meaning
// IDLE   | waiting for start (ignored while busy)
// LOAD   | acc = 1 mod n, bit index = WIDTH-1
// SQR    | acc = acc*acc mod n, WIDTH steps + writeback
// MUL    | acc = acc*c mod n, WIDTH steps + writeback
// DONE   | publish result and cycle count
module rsa_modexp_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] m_decrypted,
    output logic             finish,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int IW = $clog2(WIDTH);
`ifdef RSA_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SQR, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   c_q, d_q, n_q, acc_q, m_q;
    logic [WIDTH+1:0]   r_q;
    logic [IW-1:0]      i_q, j_q;
    logic               wb_q, busy_q, finish_q;
    logic [CNT_W-1:0]   cnt_q, cc_q;

    logic accept, load_en, step_en, wb_en, bit_end, acc_we, done_en;
    logic mul_req, b_bit;

    function automatic logic [WIDTH+1:0] modmul_step(input logic [WIDTH+1:0] r,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] nm,
                                                     input logic             b);
        logic [WIDTH+1:0] t, nn;
        nn = {2'b00, nm};
        t  = {r[WIDTH:0], 1'b0};
        if (t >= nn) t = t - nn;
        if (b)       t = t + {2'b00, a};
        if (t >= nn) t = t - nn;
        return t;
    endfunction

    assign mul_req = CONST_TIME || d_q[i_q];
    assign b_bit   = (state_q == S_MUL) ? c_q[j_q] : acc_q[j_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && !busy_q) state_d = S_LOAD;
            S_LOAD: state_d = S_SQR;
            S_SQR: begin
                if (wb_q) begin
                    if (mul_req)          state_d = S_MUL;
                    else if (i_q == '0)   state_d = S_DONE;
                    else                  state_d = S_SQR;
                end
            end
            S_MUL:  if (wb_q) state_d = (i_q == '0) ? S_DONE : S_SQR;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == S_IDLE) && start && !busy_q;
        load_en = (state_q == S_LOAD);
        step_en = ((state_q == S_SQR) || (state_q == S_MUL)) && !wb_q;
        wb_en   = ((state_q == S_SQR) || (state_q == S_MUL)) && wb_q;
        bit_end = wb_en && ((state_q == S_MUL) || !mul_req);
        // In constant-time mode a MUL for a zero bit still runs but its product is dropped.
        acc_we  = wb_en && ((state_q == S_SQR) || d_q[i_q]);
        done_en = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            r_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            wb_q     <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            cnt_q    <= '0;
            cc_q     <= '0;
        end else begin
            if (accept) begin
                c_q    <= c;
                d_q    <= d;
                n_q    <= n;
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(1);
            end else if ((state_q != S_IDLE) && (cnt_q != '1)) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
            if (finish_q) busy_q <= 1'b0;
            if (load_en) begin
                acc_q <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                i_q   <= IW'(WIDTH - 1);
                j_q   <= IW'(WIDTH - 1);
                r_q   <= '0;
                wb_q  <= 1'b0;
            end
            if (step_en) begin
                r_q <= modmul_step(r_q, acc_q, n_q, b_bit);
                if (j_q == '0) wb_q <= 1'b1;
                else           j_q  <= j_q - IW'(1);
            end
            if (wb_en) begin
                if (acc_we) acc_q <= r_q[WIDTH-1:0];
                r_q  <= '0;
                j_q  <= IW'(WIDTH - 1);
                wb_q <= 1'b0;
            end
            if (bit_end) i_q <= i_q - IW'(1);
            finish_q <= done_en;
            if (done_en) begin
                m_q  <= acc_q;
                cc_q <= cnt_q;
            end
        end
    end

    assign m_decrypted = m_q;
    assign finish      = finish_q;
    assign busy        = busy_q;
    assign cycle_count = cc_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed bench for rsa_modexp_engine: 16-bit and 32-bit instances, scoreboard of expected
// results and latencies from a reference model; honours RSA_CONST_TIME_EN.
module tb_rsa_modexp_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start32;
    logic [15:0] c16, d16, n16, m16;
    logic [31:0] c32, d32, n32, m32;
    logic        fin16, fin32, busy16, busy32;
    logic [31:0] cc16, cc32;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint unsigned m;
        int              lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rsa_modexp_engine #(.WIDTH(16), .CNT_W(32)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .c(c16), .d(d16), .n(n16),
        .m_decrypted(m16), .finish(fin16), .busy(busy16), .cycle_count(cc16)
    );

    rsa_modexp_engine #(.WIDTH(32), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .c(c32), .d(d32), .n(n32),
        .m_decrypted(m32), .finish(fin32), .busy(busy32), .cycle_count(cc32)
    );

    function automatic longint unsigned model(input longint unsigned cc, input longint unsigned dd,
                                              input longint unsigned nn, input int w);
        longint unsigned r;
        r = 1 % nn;
        for (int i = w - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (dd[i]) r = (r * cc) % nn;
        end
        return r;
    endfunction

    function automatic int exp_lat(input longint unsigned dd, input int w);
`ifdef RSA_CONST_TIME_EN
        return 2 + 2 * w * (w + 1) + 0 * $countones(dd);
`else
        return 2 + (w + $countones(dd)) * (w + 1);
`endif
    endfunction

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit w32, input longint unsigned cc, input longint unsigned dd,
                          input longint unsigned nn);
        exp_t e;
        int   w;
        w = w32 ? 32 : 16;
        @(negedge clk);
        if (w32) begin
            c32 = cc[31:0]; d32 = dd[31:0]; n32 = nn[31:0]; start32 = 1'b1;
        end else begin
            c16 = cc[15:0]; d16 = dd[15:0]; n16 = nn[15:0]; start16 = 1'b1;
        end
        e.m   = model(cc, dd, nn, w);
        e.lat = exp_lat(dd, w);
        sb.push_back(e);
        @(posedge clk); #1;
        start16 = 1'b0;
        start32 = 1'b0;
        c16 = 16'($urandom); d16 = 16'($urandom); n16 = 16'($urandom);
        c32 = $urandom;      d32 = $urandom;      n32 = $urandom;
        check("busy_after_start", w32 ? busy32 : busy16, 1);
    endtask

    task automatic await(input bit w32, input int poke_at, output int lat);
        exp_t e;
        bit   got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 5000) begin
            if (lat == poke_at) begin
                if (w32) start32 = 1'b1;
                else     start16 = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
            start16 = 1'b0;
            start32 = 1'b0;
            if (w32 ? fin32 : fin16) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            check("finish_timeout", 0, 1);
        end else begin
            check("result",      w32 ? m32 : m16, e.m);
            check("latency",     lat, e.lat);
            check("cycle_count", w32 ? cc32 : cc16, e.lat);
            check("busy_in_finish", w32 ? busy32 : busy16, 1);
            @(posedge clk); #1;
            check("finish_one_cycle", w32 ? fin32 : fin16, 0);
            check("busy_cleared",     w32 ? busy32 : busy16, 0);
        end
    endtask

    initial begin
        int lat, lat_a, lat_b;
        longint unsigned rn, rc, rd;
        rst = 1'b1;
        start16 = 1'b0; start32 = 1'b0;
        c16 = '0; d16 = '0; n16 = '0;
        c32 = '0; d32 = '0; n32 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m",      m16, 0);
        check("reset_finish", fin16, 0);
        check("reset_busy",   busy16, 0);
        check("reset_count",  cc16, 0);
        @(negedge clk);
        rst = 1'b0;

        launch(0, 1394, 2011, 3127);
        await(0, -1, lat);
        check("vec1_m", m16, 89);
`ifdef RSA_CONST_TIME_EN
        check("vec1_lat", lat, 546);
`else
        check("vec1_lat", lat, 427);
`endif

        launch(0, 5, 0, 23);
        await(0, -1, lat);
        check("d0_m", m16, 1);
`ifndef RSA_CONST_TIME_EN
        check("d0_lat", lat, 274);
`endif
        launch(0, 0, 7, 23);
        await(0, -1, lat);
        check("c0_m", m16, 0);
        launch(0, 5, 7, 1);
        await(0, -1, lat);
        check("n1_m", m16, 0);

        launch(1, 4, 13, 497);
        await(1, -1, lat);
        check("w32_m", m32, 445);
`ifdef RSA_CONST_TIME_EN
        check("w32_lat", lat, 2114);
`else
        check("w32_lat", lat, 1157);
`endif

        // A start during the run carries different (random) operands and must be dropped.
        launch(0, 1394, 2011, 3127);
        await(0, 50, lat);
        check("poke_m", m16, 89);

        launch(0, 1111, 3001, 3127);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_m",      m16, 0);
        check("abort_finish", fin16, 0);
        check("abort_busy",   busy16, 0);
        check("abort_count",  cc16, 0);
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            rn = longint'($urandom_range(65535, 2));
            rc = longint'($urandom_range(32'(rn - 1), 0));
            rd = longint'($urandom_range(65535, 0));
            launch(0, rc, rd, rn);
            await(0, -1, lat);
        end

        launch(0, 1394, 16'h0001, 3127);
        await(0, -1, lat_a);
        launch(0, 1394, 16'hFFFF, 3127);
        await(0, -1, lat_b);
`ifdef RSA_CONST_TIME_EN
        check("lat_delta", lat_b - lat_a, 0);
`else
        check("lat_delta", lat_b - lat_a, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
